// File: rtl/cm_stage_pkg.sv
// cm_stage_pkg: shared widths, FSM state enum and ROB head packet for the commit stage
package cm_stage_pkg;
  localparam int XLEN = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;
  typedef enum logic [1:0] {CM_RUN, CM_STORE_WAIT, CM_FLUSH, CM_HALTED} CM_STATE;
  typedef struct packed {
    logic                   valid;
    logic                   ready;
    logic [ROB_TAG_LEN-1:0] tag;
    logic [4:0]             dest_idx;
    logic [XLEN-1:0]        value;
    logic                   wr_mem;
    logic [XLEN-1:0]        mem_addr;
    logic [2:0]             mem_size;
    logic                   mispredict;
    logic [XLEN-1:0]        target_pc;
    logic                   halt;
    logic                   illegal;
  } ROB_HEAD_PACKET;
endpackage

// File: rtl/cm_store_port.sv
// cm_store_port: holds a captured store and runs the req/ack handshake while waiting
//   clk_i, rst_ni : clock, async active-low reset
//   cap_i         : capture addr_i/data_i/size_i this cycle
//   wait_i        : FSM is in STORE_WAIT
//   ack_i         : memory accepted the store
//   req_o, addr_o, data_o, size_o : store request and held fields
//   done_o        : store accepted this cycle
module cm_store_port
  import cm_stage_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cap_i,
  input  logic            wait_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      size_i,
  input  logic            ack_i,
  output logic            req_o,
  output logic [XLEN-1:0] addr_o,
  output logic [XLEN-1:0] data_o,
  output logic [2:0]      size_o,
  output logic            done_o
);
  logic [XLEN-1:0] addr_q, data_q;
  logic [2:0]      size_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      size_q <= '0;
    end else if (cap_i) begin
      addr_q <= addr_i;
      data_q <= data_i;
      size_q <= size_i;
    end
  end
  assign req_o  = wait_i;
  assign done_o = wait_i & ack_i;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign size_o = size_q;
endmodule

// File: rtl/cm_stage.sv
// cm_stage: in-order commit stage retiring the ROB head (writeback, maptable clear, stores, flush, halt)
//   clock, reset (async active-low)
//   head_* : ROB head entry fields
//   retire, wb_reg_wr_*_out, mt_clear_* : same-cycle retirement effects
//   mem_st_* : store request/ack port with registered fields
//   flush, flush_pc : registered one-cycle mispredict redirect
//   halt_out : sticky halt
//   retired_count : retire counter, present only with CM_RETIRE_COUNT_EN defined
module cm_stage
  import cm_stage_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   head_valid,
  input  logic                   head_ready,
  input  logic [ROB_TAG_LEN-1:0] head_tag,
  input  logic [4:0]             head_dest_idx,
  input  logic [XLEN-1:0]        head_value,
  input  logic                   head_wr_mem,
  input  logic [XLEN-1:0]        head_mem_addr,
  input  logic [2:0]             head_mem_size,
  input  logic                   head_mispredict,
  input  logic [XLEN-1:0]        head_target_pc,
  input  logic                   head_halt,
  input  logic                   head_illegal,
  output logic                   retire,
  output logic                   wb_reg_wr_en_out,
  output logic [4:0]             wb_reg_wr_idx_out,
  output logic [XLEN-1:0]        wb_reg_wr_data_out,
  output logic                   mt_clear_en,
  output logic [4:0]             mt_clear_idx,
  output logic [ROB_TAG_LEN-1:0] mt_clear_tag,
  output logic                   mem_st_req,
  output logic [XLEN-1:0]        mem_st_addr,
  output logic [XLEN-1:0]        mem_st_data,
  output logic [2:0]             mem_st_size,
  input  logic                   mem_st_ack,
  output logic                   flush,
  output logic [XLEN-1:0]        flush_pc,
  output logic                   halt_out
`ifdef CM_RETIRE_COUNT_EN
  ,
  output logic [63:0]            retired_count
`endif
);
  ROB_HEAD_PACKET head;
  CM_STATE state_q, state_d;
  logic flush_q, flush_d;
  logic [XLEN-1:0] flush_pc_q, flush_pc_d;
  logic commit, st_cap, st_done, wr;
  assign head = '{valid: head_valid, ready: head_ready, tag: head_tag, dest_idx: head_dest_idx,
                  value: head_value, wr_mem: head_wr_mem, mem_addr: head_mem_addr,
                  mem_size: head_mem_size, mispredict: head_mispredict,
                  target_pc: head_target_pc, halt: head_halt, illegal: head_illegal};
  assign commit = head.valid & head.ready;
  cm_store_port u_store (
    .clk_i  (clock),
    .rst_ni (reset),
    .cap_i  (st_cap),
    .wait_i (state_q == CM_STORE_WAIT),
    .addr_i (head.mem_addr),
    .data_i (head.value),
    .size_i (head.mem_size),
    .ack_i  (mem_st_ack),
    .req_o  (mem_st_req),
    .addr_o (mem_st_addr),
    .data_o (mem_st_data),
    .size_o (mem_st_size),
    .done_o (st_done)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= CM_RUN;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end
  // Register write and maptable clear only accompany a non-store retire from RUN.
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    wr         = 1'b0;
    st_cap     = 1'b0;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    case (state_q)
      CM_RUN: if (commit) begin
        if (head.illegal) state_d = CM_HALTED;
        else if (head.wr_mem) begin
          st_cap  = 1'b1;
          state_d = CM_STORE_WAIT;
        end else begin
          retire = 1'b1;
          wr     = head.dest_idx != ZERO_REG;
          if (head.halt) state_d = CM_HALTED;
          else if (head.mispredict) begin
            flush_d    = 1'b1;
            flush_pc_d = head.target_pc;
            state_d    = CM_FLUSH;
          end
        end
      end
      CM_STORE_WAIT: if (st_done) begin
        retire  = 1'b1;
        state_d = CM_RUN;
      end
      CM_FLUSH: state_d = CM_RUN;
      default: state_d = CM_HALTED;
    endcase
  end
  assign wb_reg_wr_en_out   = wr;
  assign wb_reg_wr_idx_out  = wr ? head.dest_idx : 5'd0;
  assign wb_reg_wr_data_out = wr ? head.value : '0;
  assign mt_clear_en        = wr;
  assign mt_clear_idx       = wr ? head.dest_idx : 5'd0;
  assign mt_clear_tag       = wr ? head.tag : '0;
  assign flush              = flush_q;
  assign flush_pc           = flush_pc_q;
  assign halt_out           = state_q == CM_HALTED;
`ifdef CM_RETIRE_COUNT_EN
  logic [63:0] count_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else if (retire) count_q <= count_q + 64'd1;
  end
  assign retired_count = count_q;
`endif
endmodule

// File: tb/tb_cm_stage.sv
// tb_cm_stage: directed self-checking bench for cm_stage
module tb_cm_stage;
  import cm_stage_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic head_valid, head_ready, head_wr_mem, head_mispredict, head_halt, head_illegal, mem_st_ack;
  logic [ROB_TAG_LEN-1:0] head_tag;
  logic [4:0] head_dest_idx;
  logic [XLEN-1:0] head_value, head_mem_addr, head_target_pc;
  logic [2:0] head_mem_size;
  logic retire, wb_reg_wr_en_out, mt_clear_en, mem_st_req, flush, halt_out;
  logic [4:0] wb_reg_wr_idx_out, mt_clear_idx;
  logic [XLEN-1:0] wb_reg_wr_data_out, mem_st_addr, mem_st_data, flush_pc;
  logic [ROB_TAG_LEN-1:0] mt_clear_tag;
  logic [2:0] mem_st_size;
`ifdef CM_RETIRE_COUNT_EN
  logic [63:0] retired_count;
`endif
  int checks = 0;
  int errors = 0;
  int pulses;
  always #5 clock = ~clock;
  cm_stage dut (
    .clock(clock), .reset(reset),
    .head_valid(head_valid), .head_ready(head_ready), .head_tag(head_tag),
    .head_dest_idx(head_dest_idx), .head_value(head_value), .head_wr_mem(head_wr_mem),
    .head_mem_addr(head_mem_addr), .head_mem_size(head_mem_size),
    .head_mispredict(head_mispredict), .head_target_pc(head_target_pc),
    .head_halt(head_halt), .head_illegal(head_illegal),
    .retire(retire), .wb_reg_wr_en_out(wb_reg_wr_en_out), .wb_reg_wr_idx_out(wb_reg_wr_idx_out),
    .wb_reg_wr_data_out(wb_reg_wr_data_out), .mt_clear_en(mt_clear_en),
    .mt_clear_idx(mt_clear_idx), .mt_clear_tag(mt_clear_tag),
    .mem_st_req(mem_st_req), .mem_st_addr(mem_st_addr), .mem_st_data(mem_st_data),
    .mem_st_size(mem_st_size), .mem_st_ack(mem_st_ack),
    .flush(flush), .flush_pc(flush_pc), .halt_out(halt_out)
`ifdef CM_RETIRE_COUNT_EN
    , .retired_count(retired_count)
`endif
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic clear_head();
    head_valid = 0; head_ready = 0; head_tag = '0; head_dest_idx = '0; head_value = '0;
    head_wr_mem = 0; head_mem_addr = '0; head_mem_size = '0; head_mispredict = 0;
    head_target_pc = '0; head_halt = 0; head_illegal = 0;
  endtask
  task automatic alu(input logic [4:0] d, input logic [31:0] v, input logic [4:0] t);
    clear_head();
    head_valid = 1; head_ready = 1; head_dest_idx = d; head_value = v; head_tag = t;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] v, input logic [2:0] s);
    clear_head();
    head_valid = 1; head_ready = 1; head_wr_mem = 1; head_mem_addr = a; head_value = v;
    head_mem_size = s;
  endtask
  task automatic do_reset();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask
  initial begin
    clear_head();
    mem_st_ack = 0;
    #1;
    check("rst_retire", retire, 0);
    check("rst_wb_en", wb_reg_wr_en_out, 0);
    check("rst_req", mem_st_req, 0);
    check("rst_flush", flush, 0);
    check("rst_halt", halt_out, 0);
    do_reset();
    // ALU retire and back-to-back throughput
    alu(5, 32'h1234, 3);
    #1;
    check("alu_retire", retire, 1);
    check("alu_wb_en", wb_reg_wr_en_out, 1);
    check("alu_wb_idx", wb_reg_wr_idx_out, 5);
    check("alu_wb_data", wb_reg_wr_data_out, 32'h1234);
    check("alu_mt_en", mt_clear_en, 1);
    check("alu_mt_idx", mt_clear_idx, 5);
    check("alu_mt_tag", mt_clear_tag, 3);
    for (int i = 1; i < 4; i++) begin
      tick();
      alu(5'(5 + i), 32'h1000 + i, 5'(3 + i));
      #1;
      check("b2b_retire", retire, 1);
      check("b2b_wb_idx", wb_reg_wr_idx_out, 5 + i);
      check("b2b_wb_data", wb_reg_wr_data_out, 32'h1000 + i);
      check("b2b_mt_tag", mt_clear_tag, 3 + i);
    end
    tick();
    // stall
    alu(6, 32'h9, 1);
    head_ready = 0;
    #1;
    check("stall_retire", retire, 0);
    check("stall_wb_en", wb_reg_wr_en_out, 0);
    check("stall_mt_en", mt_clear_en, 0);
    // dest 0
    head_ready = 1;
    head_dest_idx = 0;
    #1;
    check("d0_retire", retire, 1);
    check("d0_wb_en", wb_reg_wr_en_out, 0);
    check("d0_mt_en", mt_clear_en, 0);
    tick();
    // store with ack after 3 request cycles
    store(32'h100, 32'hAB, 2);
    #1;
    check("st_cap_retire", retire, 0);
    check("st_cap_req", mem_st_req, 0);
    pulses = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("st_req", mem_st_req, 1);
      check("st_addr", mem_st_addr, 32'h100);
      check("st_data", mem_st_data, 32'hAB);
      check("st_size", mem_st_size, 2);
      pulses += int'(retire);
      if (i < 2) tick();
    end
    mem_st_ack = 1;
    #1;
    check("st_ack_retire", retire, 1);
    check("st_ack_wb_en", wb_reg_wr_en_out, 0);
    check("st_ack_mt_en", mt_clear_en, 0);
    pulses += int'(retire);
    check("st_pulses", pulses, 1);
    tick();
    mem_st_ack = 0;
    clear_head();
    #1;
    check("st_done_req", mem_st_req, 0);
    check("st_done_retire", retire, 0);
    // mispredict
    alu(4, 32'h55, 7);
    head_mispredict = 1;
    head_target_pc = 32'h80;
    #1;
    check("mp_retire", retire, 1);
    check("mp_flush_early", flush, 0);
    tick();
    alu(8, 32'h66, 2);
    #1;
    check("mp_flush", flush, 1);
    check("mp_flush_pc", flush_pc, 32'h80);
    check("mp_bubble_retire", retire, 0);
    check("mp_bubble_wb", wb_reg_wr_en_out, 0);
    tick();
    check("mp_after_flush", flush, 0);
    check("mp_after_retire", retire, 1);
    tick();
    clear_head();
    // reset during store wait
    store(32'h200, 32'hCD, 1);
    tick();
    clear_head();
    #1;
    check("rs_req", mem_st_req, 1);
    reset = 0;
    mem_st_ack = 1;
    #1;
    check("rs_req_drop", mem_st_req, 0);
    check("rs_retire", retire, 0);
    tick();
    mem_st_ack = 0;
    tick();
    reset = 1;
    // halt with a register write
    alu(2, 32'h77, 1);
    head_halt = 1;
    #1;
    check("halt_retire", retire, 1);
    check("halt_wb_en", wb_reg_wr_en_out, 1);
    check("halt_wb_idx", wb_reg_wr_idx_out, 2);
    check("halt_early", halt_out, 0);
    tick();
    alu(9, 32'h1, 4);
    #1;
    check("halt_out", halt_out, 1);
    check("halt_ignore_retire", retire, 0);
    check("halt_ignore_wb", wb_reg_wr_en_out, 0);
    tick();
    check("halt_sticky", halt_out, 1);
    clear_head();
    // illegal
    do_reset();
    check("ill_rst_halt", halt_out, 0);
    alu(3, 32'h2, 5);
    head_illegal = 1;
    #1;
    check("ill_retire", retire, 0);
    check("ill_wb_en", wb_reg_wr_en_out, 0);
    tick();
    clear_head();
    #1;
    check("ill_halt", halt_out, 1);
    check("ill_retire_after", retire, 0);
`ifdef CM_RETIRE_COUNT_EN
    do_reset();
    check("cnt_rst", retired_count, 0);
    for (int i = 0; i < 9; i++) begin
      alu(5'(1 + i), 32'(i), 5'(i));
      tick();
      head_ready = 0;
      tick();
    end
    store(32'h300, 32'h1, 2);
    tick();
    clear_head();
    mem_st_ack = 1;
    tick();
    mem_st_ack = 0;
    tick();
    check("cnt_ten", retired_count, 10);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
